// File: rtl/decimal_key_bcd_encoder_pkg.sv
// Shared definitions for the decimal key BCD encoder: FSM state encoding and
// digit/key geometry.
package decimal_key_bcd_encoder_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned KEYS       = 10;
  localparam int unsigned DIGITS_W   = NUM_DIGITS * BCD_W;
  localparam int unsigned COUNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_EMIT         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/decimal_key_bcd_encoder_onehot10_to_bcd8421.sv
// Combinational one-hot (10 lines) to BCD 8421 encoder.
// Ports:
//   key_i      - raw key lines, bit n = key "n"
//   code_c     - BCD code of the set bit (meaningful only when one_hot_c = 1)
//   one_hot_c  - exactly one key bit is set
module onehot10_to_bcd8421
  import decimal_key_bcd_encoder_pkg::*;
(
  input  logic [KEYS-1:0]  key_i,
  output logic [BCD_W-1:0] code_c,
  output logic             one_hot_c
);

  logic [3:0] ones_c;

  // Population count and OR of set-bit indices; the code is only trusted
  // when exactly one bit is set.
  always_comb begin
    ones_c = '0;
    code_c = '0;
    for (int i = 0; i < int'(KEYS); i++) begin
      ones_c = ones_c + 4'(key_i[i]);
      if (key_i[i]) begin
        code_c = code_c | BCD_W'(i);
      end
    end
    one_hot_c = (ones_c == 4'd1);
  end

endmodule

// File: rtl/decimal_key_bcd_encoder.sv
// Debounced decimal keypad encoder with BCD output handshake, multi-key error
// pulse and a four-digit history register.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   key         - raw key lines (active-high, bit n = key "n")
//   clear       - synchronous clear of history and FSM (highest priority)
//   out_ready   - consumer accepts the presented digit
//   bcd         - accepted digit (retained while bcd_valid = 0)
//   bcd_valid   - bcd holds an unconsumed digit
//   digits      - BCD history, newest digit in [3:0]
//   count       - digits in history, saturating at NUM_DIGITS
//   err         - one-cycle pulse on multi-key press
module decimal_key_bcd_encoder
  import decimal_key_bcd_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEYS-1:0]     key,
  input  logic                clear,
  input  logic                out_ready,
  output logic [BCD_W-1:0]    bcd,
  output logic                bcd_valid,
  output logic [DIGITS_W-1:0] digits,
  output logic [COUNT_W-1:0]  count,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KEYS-1:0]     key_q, key_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                valid_q, valid_d;
  logic [DIGITS_W-1:0] digits_q, digits_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                err_q, err_d;

  logic [BCD_W-1:0]    code_c;
  logic                one_hot_c;

  // Encoder sees the live key; during DEBOUNCE it equals the captured key.
  onehot10_to_bcd8421 u_enc (
    .key_i     (key),
    .code_c    (code_c),
    .one_hot_c (one_hot_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      digits_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    bcd_d    = bcd_q;
    valid_d  = valid_q;
    digits_d = digits_q;
    count_d  = count_q;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (one_hot_c) begin
          key_d   = key;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end else if (key != '0) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_RELEASE;
        end
      end

      // Capture edge plus DEBOUNCE_CYCLES matches lands bcd_valid at t+N+1.
      ST_DEBOUNCE: begin
        if (key != key_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          cnt_d   = '0;
          bcd_d   = code_c;
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          digits_d = {digits_q[DIGITS_W-BCD_W-1:0], bcd_q};
          if (count_q < COUNT_W'(NUM_DIGITS)) begin
            count_d = count_q + COUNT_W'(1);
          end
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT_RELEASE;
        end
      end

      ST_WAIT_RELEASE: begin
        if (key != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Clear overrides everything; parking in WAIT_RELEASE blocks re-acceptance
    // of a key that is still held.
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      cnt_d    = '0;
      state_d  = ST_WAIT_RELEASE;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign digits    = digits_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_decimal_key_bcd_encoder.sv
// Directed self-checking bench for decimal_key_bcd_encoder (DEBOUNCE_CYCLES = 4).
module tb_decimal_key_bcd_encoder;
  import decimal_key_bcd_encoder_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [KEYS-1:0]     key;
  logic                clear;
  logic                out_ready;
  logic [BCD_W-1:0]    bcd;
  logic                bcd_valid;
  logic [DIGITS_W-1:0] digits;
  logic [COUNT_W-1:0]  count;
  logic                err;

  int checks   = 0;
  int failures = 0;

  decimal_key_bcd_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .clear     (clear),
    .out_ready (out_ready),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .digits    (digits),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Press key k with out_ready high, let it be accepted, then release fully.
  task automatic press_accept(input int k);
    key       = KEYS'(1) << k;
    out_ready = 1'b1;
    steps(7);
    key = '0;
    steps(5);
  endtask

  initial begin
    rst_n = 1'b0; key = '0; clear = 1'b0; out_ready = 1'b0;
    steps(2);
    chk("rst_bcd",    32'(bcd), 32'h0);
    chk("rst_valid",  32'(bcd_valid), 32'h0);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_count",  32'(count), 32'h0);
    chk("rst_err",    32'(err), 32'h0);
    rst_n = 1'b1;
    steps(2);

    // Single key 7 with ready high: valid exactly one cycle at t+5.
    key = 10'h080; out_ready = 1'b1;
    step();                                   // edge t
    steps(4);                                 // t+1..t+4
    chk("k7_valid_t4", 32'(bcd_valid), 32'h0);
    step();                                   // t+5
    chk("k7_valid_t5", 32'(bcd_valid), 32'h1);
    chk("k7_bcd",      32'(bcd), 32'h7);
    step();                                   // t+6 handshake done
    chk("k7_valid_t6", 32'(bcd_valid), 32'h0);
    chk("k7_digits",   32'(digits), 32'h0007);
    chk("k7_count",    32'(count), 32'h1);
    steps(3);                                 // key held through t+9
    chk("k7_no_repeat", 32'(bcd_valid), 32'h0);
    key = '0;
    steps(5);
    chk("k7_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Bounce: key 2 for two cycles only.
    key = 10'h004;
    steps(2);
    key = '0;
    step();
    chk("bounce_idle", 32'(dut.state_q), 32'(ST_IDLE));
    steps(6);
    chk("bounce_valid",  32'(bcd_valid), 32'h0);
    chk("bounce_digits", 32'(digits), 32'h0007);

    // Multi-key press.
    key = 10'h201;
    step();
    chk("multi_err",   32'(err), 32'h1);
    chk("multi_state", 32'(dut.state_q), 32'(ST_WAIT_RELEASE));
    key = '0;
    step();
    chk("multi_err_pulse", 32'(err), 32'h0);
    chk("multi_valid",     32'(bcd_valid), 32'h0);
    steps(2);
    chk("multi_wait3", 32'(dut.state_q), 32'(ST_WAIT_RELEASE));
    step();
    chk("multi_idle",  32'(dut.state_q), 32'(ST_IDLE));

    // Key 9 with stalled consumer; key change during EMIT ignored.
    key = 10'h200; out_ready = 1'b0;
    steps(6);
    chk("k9_valid", 32'(bcd_valid), 32'h1);
    chk("k9_bcd",   32'(bcd), 32'h9);
    key = 10'h001;
    steps(3);
    chk("k9_hold_bcd",    32'(bcd), 32'h9);
    chk("k9_hold_digits", 32'(digits), 32'h0007);
    steps(3);
    chk("k9_hold_valid", 32'(bcd_valid), 32'h1);
    chk("k9_hold_bcd2",  32'(bcd), 32'h9);
    out_ready = 1'b1;
    step();
    chk("k9_valid_clr", 32'(bcd_valid), 32'h0);
    chk("k9_retain",    32'(bcd), 32'h9);
    chk("k9_digits",    32'(digits), 32'h0079);
    chk("k9_count",     32'(count), 32'h2);
    key = '0;
    steps(5);

    // Keys 1..5: history wraps, count saturates.
    for (int k = 1; k <= 5; k++) press_accept(k);
    chk("seq_digits", 32'(digits), 32'h2345);
    chk("seq_count",  32'(count), 32'h4);
    chk("seq_bcd",    32'(bcd), 32'h5);

    // Clear in the same cycle as a handshake.
    key = 10'h008; out_ready = 1'b0;
    steps(6);
    chk("clr_pre_valid", 32'(bcd_valid), 32'h1);
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_digits", 32'(digits), 32'h0);
    chk("clr_count",  32'(count), 32'h0);
    chk("clr_valid",  32'(bcd_valid), 32'h0);
    chk("clr_state",  32'(dut.state_q), 32'(ST_WAIT_RELEASE));
    steps(6);
    chk("clr_held_valid", 32'(bcd_valid), 32'h0);
    chk("clr_held_count", 32'(count), 32'h0);
    key = '0;
    steps(5);

    // Reset asserted during DEBOUNCE, then released with key held.
    press_accept(6);
    chk("pre_rst_digits", 32'(digits), 32'h0006);
    key = 10'h020;
    steps(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digits", 32'(digits), 32'h0);
    chk("arst_count",  32'(count), 32'h0);
    chk("arst_bcd",    32'(bcd), 32'h0);
    chk("arst_state",  32'(dut.state_q), 32'(ST_IDLE));
    step();
    rst_n = 1'b1;
    steps(5);
    chk("post_rst_wait", 32'(bcd_valid), 32'h0);
    step();
    chk("post_rst_valid", 32'(bcd_valid), 32'h1);
    chk("post_rst_bcd",   32'(bcd), 32'h5);
    key = '0;
    steps(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
